id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- Pipeline register between decode and execute.
- Applies the hazard unit's forwarding selects (fwd_r1, fwd_r2, alu_fwd) to the decoded operands before latching them.
- Turns flush_jump and branch_flush into bubbles.
- Detects load-use hazards and requests a one-cycle stall from upstream. All EX-stage control and operands come from this block.

Parameters:
- DATA_W, 32, operand/immediate width
- REG_W, 4, register index width (16 registers, r0 hard-wired to zero)
- OP_W, 4, ALU opcode width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall_in  in  1  external hold (e.g. memory wait); freeze all EX registers
- flush_jump  in  1  kill the instruction in ID (jump taken)
- branch_flush  in  1  kill the instruction in ID (branch taken)
- id_valid  in  1  ID holds a real instruction
- id_r1  in  REG_W  source register 1 index
- id_r2  in  REG_W  source register 2 index
- id_rd  in  REG_W  destination register index
- id_r1_data  in  DATA_W  register file read data 1
- id_r2_data  in  DATA_W  register file read data 2
- id_imm  in  DATA_W  sign-extended immediate
- id_alu_op  in  OP_W  ALU operation
- id_write_reg  in  1  instruction writes rd
- id_mem_read  in  1  instruction is a load
- id_mem_write  in  1  instruction is a store
- fwd_r1  in  1  substitute alu_fwd for operand A
- fwd_r2  in  1  substitute alu_fwd for operand B
- alu_fwd  in  DATA_W  forwarded ALU result
- load_use_stall  out  1  combinational; upstream must hold PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_rd  out  REG_W  destination index
- ex_op_a  out  DATA_W  operand A
- ex_op_b  out  DATA_W  operand B
- ex_imm  out  DATA_W  immediate
- ex_alu_op  out  OP_W  ALU operation
- ex_write_reg  out  1  register write enable
- ex_mem_read  out  1  load
- ex_mem_write  out  1  store

Behaviour:
- Reset: all ex_* outputs 0 on the first rising edge with reset=1. load_use_stall=0 while ex_valid=0.
- Operand select, per operand:
  - If the source index is 0, the operand is 0.
  - Otherwise, if the fwd bit is set, the operand is alu_fwd.
  - Otherwise, it is the register file data.
  - fwd_r1 and fwd_r2 may both be set; both operands then take alu_fwd.
- load_use_stall asserts when all of the following hold:
  - ex_valid=1, ex_mem_read=1, ex_rd!=0
  - id_valid=1
  - id_r1==ex_rd or id_r2==ex_rd
  - flush_jump=0, branch_flush=0, stall_in=0
- Per-edge action, first match wins:
  1. reset: clear all registers.
  2. flush_jump or branch_flush: insert a bubble.
  3. stall_in: hold every ex_* register unchanged.
  4. load_use_stall: insert a bubble.
  5. Otherwise: capture. ex_valid=id_valid, selected operands, id_* fields.
- Bubble: ex_valid, ex_write_reg, ex_mem_read, ex_mem_write, ex_rd, ex_alu_op, ex_op_a, ex_op_b and ex_imm all cleared to 0.
- Capture with id_valid=0: control bits (write_reg, mem_read, mem_write) are forced to 0 regardless of the id_* inputs.
- Latency: ID→EX is 1 cycle. A load-use hazard costs exactly 1 bubble. After the bubble ex_valid=0, so load_use_stall drops and the dependent instruction is captured on the next edge.
- Flush and stall_in in the same cycle: the flush wins and a bubble is inserted; the killed instruction never reaches EX.
- Back-to-back loads to the same rd: each dependent consumer gets its own single bubble.
- Reset mid-stall: load_use_stall falls in the same cycle as ex_valid clears; no residual state.

Optional Feature:
- Macro ID_EX_BUBBLE_CNT_EN.
- Defined:
  - Adds output bubble_count [15:0].
  - Increments by 1 on every edge that inserts a bubble, whether from flush or load-use.
  - Saturates at 16'hFFFF; cleared by reset; holds during stall_in.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then capture:
  - Stimulus: assert reset for 2 cycles, then id_valid=1, id_rd=3, id_r1_data=32'h10, id_r2_data=32'h20.
  - Response: all outputs 0 during reset; next edge ex_valid=1, ex_rd=3, ex_op_a=32'h10, ex_op_b=32'h20.
- Forwarding:
  - Stimulus: id_r1=5, fwd_r1=1, alu_fwd=32'hDEAD, id_r1_data=32'h1.
  - Response: ex_op_a=32'hDEAD.
  - Stimulus: same, but id_r1=0.
  - Response: ex_op_a=0.
- Load-use:
  - Stimulus: EX holds a load with ex_rd=4; ID reads id_r2=4.
  - Response: load_use_stall=1 for exactly 1 cycle, a bubble on the next edge (ex_valid=0), then the dependent instruction captured.
- Flush:
  - Stimulus: branch_flush=1 with id_valid=1 and id_write_reg=1.
  - Response: next edge ex_valid=0, ex_write_reg=0.
  - Stimulus: flush_jump=1 together with stall_in=1.
  - Response: bubble inserted, not a hold.
- Hold:
  - Stimulus: stall_in=1 for 3 cycles while the id_* inputs change.
  - Response: ex_* outputs unchanged; load_use_stall=0 throughout.
- ID_EX_BUBBLE_CNT_EN:
  - Stimulus: 2 flushes and 1 load-use bubble.
  - Response: bubble_count=3.
  - Stimulus: preload 16'hFFFF, then one more bubble.
  - Response: bubble_count stays 16'hFFFF.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with operand forwarding, flush bubbles and load-use stall.
// Define ID_EX_BUBBLE_CNT_EN to add a saturating bubble_count output.
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_in,
  input  logic              flush_jump,
  input  logic              branch_flush,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_r1,
  input  logic [REG_W-1:0]  id_r2,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_r1_data,
  input  logic [DATA_W-1:0] id_r2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [OP_W-1:0]   id_alu_op,
  input  logic              id_write_reg,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              fwd_r1,
  input  logic              fwd_r2,
  input  logic [DATA_W-1:0] alu_fwd,
  output logic              load_use_stall,
  output logic              ex_valid,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [OP_W-1:0]   ex_alu_op,
  output logic              ex_write_reg,
  output logic              ex_mem_read,
  output logic              ex_mem_write
`ifdef ID_EX_BUBBLE_CNT_EN
  ,output logic [15:0]      bubble_count
`endif
);
  typedef struct packed {
    logic              valid;
    logic              write_reg;
    logic              mem_read;
    logic              mem_write;
    logic [REG_W-1:0]  rd;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] imm;
  } ex_t;
  ex_t ex_q, ex_d, cap;
  logic flush, bubble;
  assign flush = flush_jump | branch_flush;
  assign load_use_stall = ex_q.valid & ex_q.mem_read & (|ex_q.rd) & id_valid &
                          ((id_r1 == ex_q.rd) | (id_r2 == ex_q.rd)) & ~flush & ~stall_in;
  assign bubble = flush | load_use_stall;
  always_comb begin
    cap.valid     = id_valid;
    cap.write_reg = id_valid & id_write_reg;
    cap.mem_read  = id_valid & id_mem_read;
    cap.mem_write = id_valid & id_mem_write;
    cap.rd        = id_rd;
    cap.alu_op    = id_alu_op;
    cap.op_a      = (id_r1 == '0) ? '0 : fwd_r1 ? alu_fwd : id_r1_data;
    cap.op_b      = (id_r2 == '0) ? '0 : fwd_r2 ? alu_fwd : id_r2_data;
    cap.imm       = id_imm;
    ex_d          = bubble ? '0 : stall_in ? ex_q : cap;
  end
  always_ff @(posedge clk) ex_q <= reset ? '0 : ex_d;
  assign ex_valid     = ex_q.valid;
  assign ex_rd        = ex_q.rd;
  assign ex_op_a      = ex_q.op_a;
  assign ex_op_b      = ex_q.op_b;
  assign ex_imm       = ex_q.imm;
  assign ex_alu_op    = ex_q.alu_op;
  assign ex_write_reg = ex_q.write_reg;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  assign cnt_d = (bubble && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign bubble_count = cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: table-driven check of id_ex_stage_reg plus bubble counter sequence.
module tb_id_ex_stage_reg;
  logic clk = 0, reset = 0, stall_in = 0, flush_jump = 0, branch_flush = 0, id_valid = 0;
  logic [3:0] id_r1 = 0, id_r2 = 0, id_rd = 0, id_alu_op = 0;
  logic [31:0] id_r1_data = 0, id_r2_data = 0, id_imm = 0, alu_fwd = 0;
  logic id_write_reg = 0, id_mem_read = 0, id_mem_write = 0, fwd_r1 = 0, fwd_r2 = 0;
  logic load_use_stall, ex_valid, ex_write_reg, ex_mem_read, ex_mem_write;
  logic [3:0] ex_rd, ex_alu_op;
  logic [31:0] ex_op_a, ex_op_b, ex_imm;
  int n_chk = 0, n_pass = 0;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] bubble_count;
`endif
  always #5 clk = ~clk;
  id_ex_stage_reg dut (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush_jump(flush_jump),
    .branch_flush(branch_flush), .id_valid(id_valid), .id_r1(id_r1), .id_r2(id_r2),
    .id_rd(id_rd), .id_r1_data(id_r1_data), .id_r2_data(id_r2_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_write_reg(id_write_reg), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .fwd_r1(fwd_r1), .fwd_r2(fwd_r2), .alu_fwd(alu_fwd),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm), .ex_alu_op(ex_alu_op),
    .ex_write_reg(ex_write_reg), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
`ifdef ID_EX_BUBBLE_CNT_EN
    , .bubble_count(bubble_count)
`endif
  );
  typedef struct {
    logic rst, fj, bf, st, v;
    logic [3:0] r1, r2, rd;
    logic [31:0] d1, d2, imm;
    logic [3:0] op;
    logic wr, mr, mw, f1, f2;
    logic [31:0] af;
    logic e_lus, e_v;
    logic [3:0] e_rd;
    logic [31:0] e_a, e_b, e_imm;
    logic [3:0] e_op;
    logic e_wr, e_mr, e_mw;
  } vec_t;
  vec_t vecs[$];
  task automatic add(input logic rst, fj, bf, st, v, input logic [3:0] r1, r2, rd,
                     input logic [31:0] d1, d2, imm, input logic [3:0] op,
                     input logic wr, mr, mw, f1, f2, input logic [31:0] af,
                     input logic e_lus, e_v, input logic [3:0] e_rd,
                     input logic [31:0] e_a, e_b, e_imm, input logic [3:0] e_op,
                     input logic e_wr, e_mr, e_mw);
    vec_t x;
    x = '{rst, fj, bf, st, v, r1, r2, rd, d1, d2, imm, op, wr, mr, mw, f1, f2, af,
          e_lus, e_v, e_rd, e_a, e_b, e_imm, e_op, e_wr, e_mr, e_mw};
    vecs.push_back(x);
  endtask
  task automatic check(input int row, input string name, input logic [31:0] act, exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
  endtask
  task automatic drive(input vec_t x);
    reset = x.rst; flush_jump = x.fj; branch_flush = x.bf; stall_in = x.st; id_valid = x.v;
    id_r1 = x.r1; id_r2 = x.r2; id_rd = x.rd; id_r1_data = x.d1; id_r2_data = x.d2;
    id_imm = x.imm; id_alu_op = x.op; id_write_reg = x.wr; id_mem_read = x.mr;
    id_mem_write = x.mw; fwd_r1 = x.f1; fwd_r2 = x.f2; alu_fwd = x.af;
  endtask
  vec_t idle;
  initial begin
    //  rst fj bf st v r1 r2 rd d1 d2 imm op wr mr mw f1 f2 af | lus v rd a b imm op wr mr mw
    add(1,0,0,0,1,1,2,3,'h55,'h66,9,1,1,0,0,0,0,0,            0,0,0,0,0,0,0,0,0,0);
    add(1,0,0,0,1,1,2,3,'h55,'h66,9,1,1,0,0,0,0,0,            0,0,0,0,0,0,0,0,0,0);
    add(0,0,0,0,1,1,2,3,'h10,'h20,7,2,1,0,0,0,0,0,            0,1,3,'h10,'h20,7,2,1,0,0);
    add(0,0,0,0,1,5,6,7,1,2,3,3,1,0,0,1,0,'hDEAD,             0,1,7,'hDEAD,2,3,3,1,0,0);
    add(0,0,0,0,1,0,6,7,1,2,3,3,1,0,0,1,1,'hDEAD,             0,1,7,0,'hDEAD,3,3,1,0,0);
    add(0,0,0,0,1,1,2,4,3,5,8,0,1,1,0,0,0,0,                  0,1,4,3,5,8,0,1,1,0);
    add(0,0,0,0,1,9,4,5,'h11,'h22,1,4,1,0,0,0,0,0,            1,0,0,0,0,0,0,0,0,0);
    add(0,0,0,0,1,9,4,5,'h11,'h22,1,4,1,0,0,0,0,0,            0,1,5,'h11,'h22,1,4,1,0,0);
    add(0,0,1,0,1,1,2,6,1,2,3,5,1,0,0,0,0,0,                  0,0,0,0,0,0,0,0,0,0);
    add(0,0,0,0,1,1,2,8,'hA,'hB,'hC,6,1,1,0,0,0,0,            0,1,8,'hA,'hB,'hC,6,1,1,0);
    add(0,0,0,1,1,8,8,9,'h77,'h88,'h99,7,0,0,1,0,0,0,         0,1,8,'hA,'hB,'hC,6,1,1,0);
    add(0,0,0,1,0,3,8,10,1,1,1,1,1,1,1,1,1,5,                 0,1,8,'hA,'hB,'hC,6,1,1,0);
    add(0,0,0,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0,                  0,1,8,'hA,'hB,'hC,6,1,1,0);
    add(0,1,0,1,1,8,2,3,1,2,3,4,1,0,0,0,0,0,                  0,0,0,0,0,0,0,0,0,0);
    add(0,0,0,0,1,1,2,4,1,2,3,0,1,1,0,0,0,0,                  0,1,4,1,2,3,0,1,1,0);
    add(0,0,0,0,1,4,0,4,5,6,7,0,1,1,0,0,0,0,                  1,0,0,0,0,0,0,0,0,0);
    add(0,0,0,0,1,4,0,4,5,6,7,0,1,1,0,0,0,0,                  0,1,4,5,0,7,0,1,1,0);
    add(0,0,0,0,1,3,4,2,'h31,'h32,'h33,1,1,0,0,0,0,0,         1,0,0,0,0,0,0,0,0,0);
    add(0,0,0,0,1,3,4,2,'h31,'h32,'h33,1,1,0,0,0,0,0,         0,1,2,'h31,'h32,'h33,1,1,0,0);
    add(0,0,0,0,0,2,3,4,'h41,'h42,'h43,2,1,1,1,0,0,0,         0,0,4,'h41,'h42,'h43,2,0,0,0);
    add(0,0,0,0,1,1,2,0,1,2,3,0,1,1,0,0,0,0,                  0,1,0,1,2,3,0,1,1,0);
    add(0,0,0,0,1,0,0,3,1,2,3,0,1,0,0,0,0,0,                  0,1,3,0,0,3,0,1,0,0);
    add(0,0,0,0,1,1,2,5,1,2,3,0,1,1,0,0,0,0,                  0,1,5,1,2,3,0,1,1,0);
    add(1,0,0,0,1,5,2,6,9,8,7,3,1,0,0,0,0,0,                  1,0,0,0,0,0,0,0,0,0);
    add(0,0,0,0,1,5,2,6,9,8,7,3,1,0,0,0,0,0,                  0,1,6,9,8,7,3,1,0,0);
    add(0,0,0,0,1,1,2,3,1,2,3,0,0,0,1,0,0,0,                  0,1,3,1,2,3,0,0,0,1);
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1 check(i, "load_use_stall", 32'(load_use_stall), 32'(vecs[i].e_lus));
      @(posedge clk);
      #1;
      check(i, "ex_valid", 32'(ex_valid), 32'(vecs[i].e_v));
      check(i, "ex_rd", 32'(ex_rd), 32'(vecs[i].e_rd));
      check(i, "ex_op_a", ex_op_a, vecs[i].e_a);
      check(i, "ex_op_b", ex_op_b, vecs[i].e_b);
      check(i, "ex_imm", ex_imm, vecs[i].e_imm);
      check(i, "ex_alu_op", 32'(ex_alu_op), 32'(vecs[i].e_op));
      check(i, "ex_write_reg", 32'(ex_write_reg), 32'(vecs[i].e_wr));
      check(i, "ex_mem_read", 32'(ex_mem_read), 32'(vecs[i].e_mr));
      check(i, "ex_mem_write", 32'(ex_mem_write), 32'(vecs[i].e_mw));
    end
`ifdef ID_EX_BUBBLE_CNT_EN
    idle = '{default: '0};
    @(negedge clk); drive(idle); reset = 1;
    @(negedge clk); reset = 0; branch_flush = 1;
    @(negedge clk); branch_flush = 0; flush_jump = 1;
    @(negedge clk); flush_jump = 0; id_valid = 1; id_rd = 4; id_mem_read = 1;
    @(negedge clk); id_mem_read = 0; id_rd = 5; id_r1 = 4;
    @(negedge clk); drive(idle); stall_in = 1;
    @(negedge clk); stall_in = 0;
    check(100, "bubble_count_3", 32'(bubble_count), 32'd3);
    flush_jump = 1;
    repeat (65532) @(negedge clk);
    check(101, "bubble_count_max", 32'(bubble_count), 32'hFFFF);
    @(negedge clk);
    check(102, "bubble_count_sat", 32'(bubble_count), 32'hFFFF);
    flush_jump = 0;
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
